// File: rtl/roe_ctrl_seq.sv
// roe_ctrl_seq -- registered, handshaked instruction decoder for the R.O.E core.
//
// It accepts one 9-bit instruction for each valid/ready transfer. One cycle
// after the accepting edge it presents registered datapath controls. It also
// holds the three persistent register alias pointers (read0, read1, write),
// which are rewritten by REDEF. LW/SW keep their memory strobe asserted for
// MEM_LAT cycles, and fetch is back-pressured for that time.
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr_ready is low only while a memory op is in
// flight. Fetch must hold instr stable until the transfer happens.
// ctrl_valid marks the cycles whose control outputs are live. When it is low,
// every control output is 0.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   instr_valid, instr  instruction from fetch ([8:6] op, [5:4] fun2, [5] fun1, [3:0] operand)
//   instr_ready         decoder can accept an instruction this cycle
//   ctrl_valid          control outputs are live this cycle
//   rd0_ptr, rd1_ptr, wr_ptr   persistent alias pointers
//   reg_imm, reg_write_src, reg_read_write, reg_write_read, reg_write   datapath selects
//   mem_read, mem_write data-memory strobes
//   alu_op, alu_src     ALU operation and B-source select
//   state_dbg           current FSM state (0 IDLE, 1 ISSUE, 2 MEM)
module roe_ctrl_seq #(
    parameter int PTR_W    = 2,
    parameter int MEM_LAT  = 2,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [8:0]          instr,
    output logic                instr_ready,
    output logic                ctrl_valid,
    output logic [PTR_W-1:0]    rd0_ptr,
    output logic [PTR_W-1:0]    rd1_ptr,
    output logic [PTR_W-1:0]    wr_ptr,
    output logic                reg_imm,
    output logic                reg_write_src,
    output logic                reg_read_write,
    output logic                reg_write_read,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          alu_src,
    output logic [1:0]          state_dbg
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SHIFTL = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SHIFTR = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLB    = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_BNZ    = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(9);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_MEM   = 2'd2
    } state_t;

    typedef struct packed {
        logic                reg_imm;
        logic                reg_write_src;
        logic                reg_read_write;
        logic                reg_write_read;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [ALU_OP_W-1:0] alu_op;
        logic [1:0]          alu_src;
    } ctrl_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic               ctrl_valid_q, ctrl_valid_d;
    logic [PTR_W-1:0]   rd0_q, rd0_d, rd1_q, rd1_d, wr_q, wr_d;

    // Decode of the instruction currently presented by fetch.
    ctrl_t      dec_ctrl;
    logic       dec_is_mem;
    logic       dec_is_redef;
    logic [2:0] op;
    logic [1:0] fun2;
    logic       fun1;
    logic       xfer;

    assign op   = instr[8:6];
    assign fun2 = instr[5:4];
    assign fun1 = instr[5];

    always_comb begin
        dec_ctrl     = '0;
        dec_is_mem   = 1'b0;
        dec_is_redef = 1'b0;
        case (op)
            3'd0: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 2'b01;
                dec_ctrl.alu_op    = ALU_SLB;
            end
            3'd1, 3'd2: begin
                dec_ctrl.reg_imm        = 1'b1;
                dec_ctrl.reg_read_write = 1'b1;
                dec_ctrl.reg_write_read = 1'b1;
                dec_ctrl.reg_write      = 1'b1;
                if (op == 3'd1) dec_ctrl.alu_op = fun1 ? ALU_SUB : ALU_ADD;
                else            dec_ctrl.alu_op = fun1 ? ALU_SHIFTR : ALU_SHIFTL;
            end
            3'd3: begin
                case (fun2)
                    2'b00: dec_is_redef = 1'b1;
                    2'b01: begin
                        dec_is_mem              = 1'b1;
                        dec_ctrl.reg_read_write = 1'b1;
                        dec_ctrl.reg_write_src  = 1'b1;
                        dec_ctrl.mem_read       = 1'b1;
                        // A single-cycle LW is already in its final cycle.
                        dec_ctrl.reg_write      = (MEM_LAT == 1);
                    end
                    2'b10: begin
                        dec_is_mem              = 1'b1;
                        dec_ctrl.reg_write_read = 1'b1;
                        dec_ctrl.mem_write      = 1'b1;
                    end
                    default: begin
                        dec_ctrl.reg_write_read = 1'b1;
                        dec_ctrl.alu_op         = ALU_BNZ;
                        dec_ctrl.alu_src        = 2'b10;
                    end
                endcase
            end
            default: begin
                dec_ctrl.reg_write_read = 1'b1;
                dec_ctrl.reg_write      = 1'b1;
                dec_ctrl.alu_src        = 2'b10;
                case (op)
                    3'd4:    dec_ctrl.alu_op = ALU_SLT;
                    3'd5:    dec_ctrl.alu_op = ALU_XOR;
                    3'd6:    dec_ctrl.alu_op = ALU_AND;
                    default: dec_ctrl.alu_op = ALU_OR;
                endcase
            end
        endcase
    end

    assign xfer = instr_valid && (state_q != S_MEM);

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        ctrl_d  = '0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        wr_d    = wr_q;
        if (state_q == S_MEM) begin
            if (cnt_q != '0) begin
                state_d          = S_MEM;
                cnt_d            = cnt_q - CNT_W'(1);
                ctrl_d           = ctrl_q;
                // LW writes back only in the cycle where the counter reaches 0.
                ctrl_d.reg_write = ctrl_q.mem_read && (cnt_q == CNT_W'(1));
            end
        end else if (xfer) begin
            ctrl_d = dec_ctrl;
            if (dec_is_mem) begin
                state_d = S_MEM;
                cnt_d   = CNT_W'(MEM_LAT - 1);
            end else begin
                state_d = S_ISSUE;
            end
            if (dec_is_redef) begin
                case (instr[3:2])
                    2'b00: rd0_d = PTR_W'(instr[1:0]);
                    2'b01: rd1_d = PTR_W'(instr[1:0]);
                    2'b10: wr_d  = PTR_W'(instr[1:0]);
                    default: begin
                        rd0_d = '0;
                        rd1_d = '0;
                        wr_d  = '0;
                    end
                endcase
            end
        end
        ctrl_valid_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
            wr_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            wr_q         <= wr_d;
        end
    end

    assign instr_ready    = (state_q != S_MEM);
    assign ctrl_valid     = ctrl_valid_q;
    assign rd0_ptr        = rd0_q;
    assign rd1_ptr        = rd1_q;
    assign wr_ptr         = wr_q;
    assign reg_imm        = ctrl_q.reg_imm;
    assign reg_write_src  = ctrl_q.reg_write_src;
    assign reg_read_write = ctrl_q.reg_read_write;
    assign reg_write_read = ctrl_q.reg_write_read;
    assign reg_write      = ctrl_q.reg_write;
    assign mem_read       = ctrl_q.mem_read;
    assign mem_write      = ctrl_q.mem_write;
    assign alu_op         = ctrl_q.alu_op;
    assign alu_src        = ctrl_q.alu_src;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_roe_ctrl_seq.sv
// Testbench for roe_ctrl_seq. The main instance uses MEM_LAT=3.
// A second instance uses MEM_LAT=4 and exercises reset asserted mid-SW.
// The control vector is packed as
// {alu_src, alu_op, mem_write, mem_read, reg_write, reg_write_read,
//  reg_read_write, reg_write_src, reg_imm}.
module tb_roe_ctrl_seq;
  localparam int LAT_A = 3;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (MEM_LAT=3)
  logic       rst, instr_valid, instr_ready, ctrl_valid;
  logic [8:0] instr;
  logic [1:0] rd0_ptr, rd1_ptr, wr_ptr, alu_src, state_dbg;
  logic       reg_imm, reg_write_src, reg_read_write, reg_write_read, reg_write;
  logic       mem_read, mem_write;
  logic [3:0] alu_op;
  logic [12:0] ctrl_vec;
  assign ctrl_vec = {alu_src, alu_op, mem_write, mem_read, reg_write, reg_write_read,
                     reg_read_write, reg_write_src, reg_imm};

  roe_ctrl_seq #(.PTR_W(2), .MEM_LAT(LAT_A), .ALU_OP_W(4)) u_dut (
    .clk(clk), .reset(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ctrl_valid(ctrl_valid),
    .rd0_ptr(rd0_ptr), .rd1_ptr(rd1_ptr), .wr_ptr(wr_ptr),
    .reg_imm(reg_imm), .reg_write_src(reg_write_src), .reg_read_write(reg_read_write),
    .reg_write_read(reg_write_read), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .alu_src(alu_src),
    .state_dbg(state_dbg));

  // ---------------- second instance (MEM_LAT=4)
  logic       b_rst, b_valid, b_ready, b_ctrl_valid;
  logic [8:0] b_instr;
  logic [1:0] b_rd0, b_rd1, b_wr, b_alu_src, b_state;
  logic       b_reg_imm, b_reg_write_src, b_reg_read_write, b_reg_write_read, b_reg_write;
  logic       b_mem_read, b_mem_write;
  logic [3:0] b_alu_op;

  roe_ctrl_seq #(.PTR_W(2), .MEM_LAT(LAT_B), .ALU_OP_W(4)) u_dut_b (
    .clk(clk), .reset(b_rst), .instr_valid(b_valid), .instr(b_instr),
    .instr_ready(b_ready), .ctrl_valid(b_ctrl_valid),
    .rd0_ptr(b_rd0), .rd1_ptr(b_rd1), .wr_ptr(b_wr),
    .reg_imm(b_reg_imm), .reg_write_src(b_reg_write_src), .reg_read_write(b_reg_read_write),
    .reg_write_read(b_reg_write_read), .reg_write(b_reg_write),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .alu_op(b_alu_op), .alu_src(b_alu_src),
    .state_dbg(b_state));

  // ---------------- scoreboard
  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference decode of one output cycle; last marks the final cycle of a LW.
  function automatic logic [12:0] model_ctrl(input logic [8:0] ins, input bit last);
    logic [1:0] src;
    logic [3:0] aop;
    logic imm, wsrc, rrw, rwr, rw, mr, mw;
    logic [2:0] o;
    src = 2'b00; aop = 4'd0; imm = 0; wsrc = 0; rrw = 0; rwr = 0; rw = 0; mr = 0; mw = 0;
    o = ins[8:6];
    if (o == 3'd0) begin
      rw = 1; src = 2'b01; aop = 4'd4;
    end else if (o == 3'd1 || o == 3'd2) begin
      imm = 1; rrw = 1; rwr = 1; rw = 1;
      aop = (o == 3'd1) ? (ins[5] ? 4'd1 : 4'd0) : (ins[5] ? 4'd3 : 4'd2);
    end else if (o == 3'd3) begin
      if (ins[5:4] == 2'b01) begin
        rrw = 1; wsrc = 1; mr = 1; rw = last;
      end else if (ins[5:4] == 2'b10) begin
        rwr = 1; mw = 1;
      end else if (ins[5:4] == 2'b11) begin
        rwr = 1; aop = 4'd5; src = 2'b10;
      end
    end else begin
      rwr = 1; rw = 1; src = 2'b10;
      aop = (o == 3'd4) ? 4'd6 : (o == 3'd5) ? 4'd7 : (o == 3'd6) ? 4'd8 : 4'd9;
    end
    return {src, aop, mw, mr, rw, rwr, rrw, wsrc, imm};
  endfunction

  function automatic bit is_mem_op(input logic [8:0] ins);
    return (ins[8:6] == 3'd3) && (ins[5:4] == 2'b01 || ins[5:4] == 2'b10);
  endfunction

  task automatic push_instr(input logic [8:0] ins, input int lat);
    if (is_mem_op(ins)) begin
      for (int j = 0; j < lat; j++) exp_q.push_back(model_ctrl(ins, j == lat - 1));
    end else begin
      exp_q.push_back(model_ctrl(ins, 1'b0));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; b_rst = 1'b1; instr_valid = 1'b0; instr = '0; b_valid = 1'b0; b_instr = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", instr_ready); end
    n_checks++;
    if (ctrl_valid !== 1'b0 || ctrl_vec !== 13'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got valid=%0b vec=%0h expected 0/0", ctrl_valid, ctrl_vec);
    end
    n_checks++;
    if ({rd0_ptr, rd1_ptr, wr_ptr} !== 6'd0 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_ptrs: got %0h state %0d expected 0", {rd0_ptr, rd1_ptr, wr_ptr}, state_dbg);
    end
    rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_add;
    logic [12:0] e;
    @(negedge clk);
    instr = 9'b001_0_00101; instr_valid = 1'b1;
    push_instr(instr, LAT_A);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (ctrl_valid !== 1'b1 || ctrl_vec !== e) begin
      n_fail++; $display("FAIL add_ctrl: got valid=%0b vec=%0h expected 1/%0h", ctrl_valid, ctrl_vec, e);
    end
    n_checks++;
    if (alu_op !== 4'd0 || reg_imm !== 1'b1 || reg_write !== 1'b1) begin
      n_fail++; $display("FAIL add_fields: got op=%0d imm=%0b rw=%0b expected 0/1/1", alu_op, reg_imm, reg_write);
    end
    @(negedge clk);
    n_checks++;
    if (ctrl_valid !== 1'b0 || ctrl_vec !== 13'd0) begin
      n_fail++; $display("FAIL add_idle: got valid=%0b vec=%0h expected 0/0", ctrl_valid, ctrl_vec);
    end
  endtask

  task automatic test_redef;
    instr = 9'b011_00_10_11; instr_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_ptr !== 2'd3 || rd0_ptr !== 2'd0 || rd1_ptr !== 2'd0) begin
      n_fail++; $display("FAIL redef_wr: got rd0=%0d rd1=%0d wr=%0d expected 0/0/3", rd0_ptr, rd1_ptr, wr_ptr);
    end
    n_checks++;
    if (ctrl_valid !== 1'b1 || ctrl_vec !== 13'd0) begin
      n_fail++; $display("FAIL redef_ctrl: got valid=%0b vec=%0h expected 1/0", ctrl_valid, ctrl_vec);
    end
    instr = 9'b011_00_01_10;
    @(negedge clk);
    n_checks++;
    if (rd1_ptr !== 2'd2 || wr_ptr !== 2'd3 || rd0_ptr !== 2'd0) begin
      n_fail++; $display("FAIL redef_rd1: got rd0=%0d rd1=%0d wr=%0d expected 0/2/3", rd0_ptr, rd1_ptr, wr_ptr);
    end
    instr = 9'b011_00_11_00;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++;
    if ({rd0_ptr, rd1_ptr, wr_ptr} !== 6'd0) begin
      n_fail++; $display("FAIL redef_clear: got %0h expected 0", {rd0_ptr, rd1_ptr, wr_ptr});
    end
    @(negedge clk);
  endtask

  task automatic test_lw_hold;
    logic [12:0] e;
    instr = 9'b011_01_0000; instr_valid = 1'b1;
    push_instr(instr, LAT_A);
    for (int c = 0; c < LAT_A; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_valid !== 1'b1 || ctrl_vec !== e || instr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL lw_cycle%0d: got valid=%0b vec=%0h ready=%0b expected 1/%0h/0",
                 c, ctrl_valid, ctrl_vec, instr_ready, e);
      end
    end
    instr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl_valid !== 1'b0 || mem_read !== 1'b0 || instr_ready !== 1'b1 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL lw_after: got valid=%0b mr=%0b ready=%0b state=%0d expected 0/0/1/0",
                         ctrl_valid, mem_read, instr_ready, state_dbg);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] seq [4];
    logic [12:0] e;
    seq[0] = 9'b101_00_0011; seq[1] = 9'b110_00_0101;
    seq[2] = 9'b111_00_1001; seq[3] = 9'b100_00_0110;
    for (int i = 0; i < 4; i++) begin
      instr = seq[i]; instr_valid = 1'b1;
      push_instr(instr, LAT_A);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_valid !== 1'b1 || ctrl_vec !== e || alu_src !== 2'b10) begin
        n_fail++; $display("FAIL b2b_%0d: got valid=%0b vec=%0h expected 1/%0h", i, ctrl_valid, ctrl_vec, e);
      end
    end
    instr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got valid=%0b expected 0", ctrl_valid); end
  endtask

  task automatic test_reset_mid_mem;
    b_instr = 9'b011_00_00_10; b_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b_rd0 !== 2'd2) begin n_fail++; $display("FAIL rmm_redef: got rd0=%0d expected 2", b_rd0); end
    b_instr = 9'b011_10_0000;
    @(negedge clk);
    b_valid = 1'b0;
    n_checks++;
    if (b_mem_write !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmm_sw1: got mw=%0b ready=%0b expected 1/0", b_mem_write, b_ready);
    end
    @(posedge clk); #2;
    n_checks++;
    if (b_mem_write !== 1'b1) begin n_fail++; $display("FAIL rmm_sw2: got mw=%0b expected 1", b_mem_write); end
    b_rst = 1'b1;
    #1;
    n_checks++;
    if (b_mem_write !== 1'b0 || b_ctrl_valid !== 1'b0 || b_rd0 !== 2'd0 || b_state !== 2'd0) begin
      n_fail++; $display("FAIL rmm_abort: got mw=%0b valid=%0b rd0=%0d state=%0d expected 0/0/0/0",
                         b_mem_write, b_ctrl_valid, b_rd0, b_state);
    end
    @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_ready !== 1'b1 || b_state !== 2'd0 || b_ctrl_valid !== 1'b0 || b_mem_write !== 1'b0) begin
      n_fail++; $display("FAIL rmm_release: got ready=%0b state=%0d valid=%0b mw=%0b expected 1/0/0/0",
                         b_ready, b_state, b_ctrl_valid, b_mem_write);
    end
  endtask

  // Random traffic; the bench tracks readiness from what it has popped.
  task automatic test_random;
    logic [12:0] e;
    logic [1:0] m_rd0, m_rd1, m_wr;
    bit last_mem, exp_ready, exp_valid;
    logic [8:0] ins;
    m_rd0 = 2'd0; m_rd1 = 2'd0; m_wr = 2'd0; last_mem = 1'b0;
    for (int cyc = 0; cyc < 130; cyc++) begin
      @(negedge clk);
      exp_valid = (exp_q.size() != 0);
      e = exp_valid ? exp_q.pop_front() : 13'd0;
      last_mem = exp_valid && (e[6] || e[5]);
      exp_ready = !last_mem;
      n_checks++;
      if (ctrl_valid !== exp_valid || ctrl_vec !== e) begin
        n_fail++; $display("FAIL rnd_ctrl c%0d: got valid=%0b vec=%0h expected %0b/%0h",
                           cyc, ctrl_valid, ctrl_vec, exp_valid, e);
      end
      n_checks++;
      if (instr_ready !== exp_ready || {rd0_ptr, rd1_ptr, wr_ptr} !== {m_rd0, m_rd1, m_wr}) begin
        n_fail++; $display("FAIL rnd_state c%0d: got ready=%0b ptrs=%0h expected %0b/%0h",
                           cyc, instr_ready, {rd0_ptr, rd1_ptr, wr_ptr}, exp_ready, {m_rd0, m_rd1, m_wr});
      end
      ins = 9'($urandom_range(0, 511));
      if (cyc >= 115) begin
        instr_valid = 1'b0;
      end else if (!exp_ready) begin
        // Presented while busy: must be ignored.
        instr_valid = 1'($urandom_range(0, 1));
        instr = ins;
      end else if ($urandom_range(0, 3) != 0) begin
        instr_valid = 1'b1;
        instr = ins;
        push_instr(ins, LAT_A);
        if (ins[8:4] == 5'b011_00) begin
          case (ins[3:2])
            2'b00: m_rd0 = ins[1:0];
            2'b01: m_rd1 = ins[1:0];
            2'b10: m_wr = ins[1:0];
            default: begin m_rd0 = 2'd0; m_rd1 = 2'd0; m_wr = 2'd0; end
          endcase
        end
      end else begin
        instr_valid = 1'b0;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_redef();
    test_lw_hold();
    test_back_to_back();
    test_reset_mid_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
